instruction_sequencer: RTL and testbench

- Upstream stage of control_unit. Owns a host-writable instruction memory and runs the fetch/execute sequence, presenting one 16-bit instruction word per issue slot to control_unit.
- Holds COMPUTE on the bus for a programmable number of cycles so the systolic wavefront can drain.
- Provides the start/busy/done handshake to the host.

---
 rtl/instruction_sequencer.sv | 137 +++++++++++++
 tb/tb_instruction_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: host-loaded imem, fetch/execute issue to control_unit.
// Holds COMPUTE words for a programmable drain window.
module instruction_sequencer #(
    parameter int IMEM_DEPTH     = 8,
    parameter int PC_W           = 3,
    parameter int COMPUTE_CYCLES = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            host_wr_en,
    input  logic [PC_W-1:0] host_wr_addr,
    input  logic [15:0]     host_wr_data,
    input  logic            start,
    output logic [15:0]     instruction,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int CNT_W =
        (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COMPUTE_CYCLES - 1);
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(IMEM_DEPTH - 1);
    localparam logic [2:0]       OP_NOP     = 3'b000;
    localparam logic [2:0]       OP_COMPUTE = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXECUTE,
        FINISH
    } state_t;

    state_t state, state_nx;

    logic [15:0]     imem [IMEM_DEPTH];
    logic [15:0]     fetch_word;
    logic [2:0]      fetch_op;
    logic [15:0]     instr_nx;
    logic [PC_W-1:0] pc_nx;
    logic            err_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic            hold;

    assign fetch_word = imem[pc];
    assign fetch_op   = fetch_word[15:13];
    assign hold = (instruction[15:13] == OP_COMPUTE) && (cnt != CNT_LAST);

    assign busy = (state == FETCH) || (state == EXECUTE);
    assign done = (state == FINISH);

    // Host writes land only while idle; a run never sees its program change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < IMEM_DEPTH; i++) begin
                imem[i] <= '0;
            end
        end else if (state == IDLE && host_wr_en) begin
            imem[host_wr_addr] <= host_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            instruction <= '0;
            pc          <= '0;
            err         <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_nx;
            instruction <= instr_nx;
            pc          <= pc_nx;
            err         <= err_nx;
            cnt         <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        instr_nx = instruction;
        pc_nx    = pc;
        err_nx   = err;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                instr_nx = '0;
                if (start) begin
                    state_nx = FETCH;
                    pc_nx    = '0;
                    err_nx   = 1'b0;
                end
            end
            FETCH: begin
                instr_nx = '0;
                cnt_nx   = '0;
                unique case (1'b1)
                    fetch_op == OP_NOP: begin
                        state_nx = FINISH;
                    end
                    fetch_op[2:1] == 2'b11: begin
                        state_nx = FINISH;
                        err_nx   = 1'b1;
                    end
                    default: begin
                        state_nx = EXECUTE;
                        instr_nx = fetch_word;
                    end
                endcase
            end
            EXECUTE: begin
                if (hold) begin
                    cnt_nx = cnt + 1'b1;
                end else begin
                    cnt_nx   = '0;
                    instr_nx = '0;
                    if (pc == PC_LAST) begin
                        state_nx = FINISH;
                    end else begin
                        pc_nx    = pc + 1'b1;
                        state_nx = FETCH;
                    end
                end
            end
            FINISH: begin
                instr_nx = '0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                instr_nx = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: two instances (hold 6 and 3) checked
// cycle by cycle against a program-walking reference trace.
module tb_instruction_sequencer;

    typedef struct packed {
        logic [15:0] ins;
        logic        busy;
        logic        done;
        logic [2:0]  pc;
        logic        err;
    } obs_t;

    logic        clk;
    logic        reset;
    logic        host_wr_en;
    logic [2:0]  host_wr_addr;
    logic [15:0] host_wr_data;
    logic        start;

    logic [15:0] ins6, ins3;
    logic [2:0]  pc6, pc3;
    logic        busy6, busy3, done6, done3, err6, err3;
    obs_t        obs [2];

    int vectors;
    int miscompares;

    logic [15:0] mem [8];
    obs_t        expq [2][$];
    logic [2:0]  fin_pc [2];
    logic        fin_err [2];

    instruction_sequencer #(
        .IMEM_DEPTH(8), .PC_W(3), .COMPUTE_CYCLES(6)
    ) dut6 (
        .clk(clk), .reset(reset), .host_wr_en(host_wr_en),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .start(start), .instruction(ins6), .pc(pc6),
        .busy(busy6), .done(done6), .err(err6)
    );

    instruction_sequencer #(
        .IMEM_DEPTH(8), .PC_W(3), .COMPUTE_CYCLES(3)
    ) dut3 (
        .clk(clk), .reset(reset), .host_wr_en(host_wr_en),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .start(start), .instruction(ins3), .pc(pc3),
        .busy(busy3), .done(done3), .err(err3)
    );

    assign obs[0] = {ins6, busy6, done6, pc6, err6};
    assign obs[1] = {ins3, busy3, done3, pc3, err3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [15:0] i, input logic b,
                                input logic d, input logic [2:0] p,
                                input logic e);
        obs_t o;
        o.ins = i; o.busy = b; o.done = d; o.pc = p; o.err = e;
        return o;
    endfunction

    task automatic chk(input int d, input obs_t exp, input string tag);
        vectors++;
        assert (obs[d] === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d: observed %h expected %h",
                   tag, (d == 0) ? 6 : 3, obs[d], exp);
        end
    endtask

    task automatic wr(input int a, input logic [15:0] dt);
        host_wr_en   = 1'b1;
        host_wr_addr = 3'(a);
        host_wr_data = dt;
        @(posedge clk); #1;
        host_wr_en = 1'b0;
        mem[a] = dt;
    endtask

    task automatic load(input logic [15:0] p [8]);
        for (int i = 0; i < 8; i++) wr(i, p[i]);
    endtask

    // Walk the program: each word costs one bubble plus its issue length.
    task automatic build(input int d, input int cc);
        logic [15:0] w;
        logic [2:0]  op;
        int          n;
        expq[d].delete();
        fin_pc[d]  = 3'd0;
        fin_err[d] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w  = mem[i];
            op = w[15:13];
            expq[d].push_back(mk(16'h0, 1'b1, 1'b0, 3'(i), 1'b0));
            if (op == 3'd0 || op >= 3'd6) begin
                fin_pc[d]  = 3'(i);
                fin_err[d] = (op >= 3'd6);
                expq[d].push_back(mk(16'h0, 1'b0, 1'b1, 3'(i), fin_err[d]));
                break;
            end
            n = (op == 3'd4) ? cc : 1;
            repeat (n) expq[d].push_back(mk(w, 1'b1, 1'b0, 3'(i), 1'b0));
            if (i == 7) begin
                fin_pc[d] = 3'd7;
                expq[d].push_back(mk(16'h0, 1'b0, 1'b1, 3'd7, 1'b0));
            end
        end
    endtask

    // mode: 0 plain, 1 write while busy, 2 start mid-run,
    //       3 start held (restart), 4 async reset at cycle 'at'
    task automatic run(input int mode, input int at, input string name);
        int   len;
        int   tlen;
        int   sz;
        obs_t idle;
        build(0, 6);
        build(1, 3);
        tlen = expq[0].size();
        if (mode == 3) begin
            for (int d = 0; d < 2; d++) begin
                sz = expq[d].size();
                expq[d].push_back(mk(16'h0, 1'b0, 1'b0, fin_pc[d], fin_err[d]));
                for (int j = 0; j < sz; j++) expq[d].push_back(expq[d][j]);
            end
        end
        len = (expq[0].size() > expq[1].size()) ?
              expq[0].size() : expq[1].size();
        len = len + 1;
        for (int d = 0; d < 2; d++) begin
            idle = mk(16'h0, 1'b0, 1'b0, fin_pc[d], fin_err[d]);
            while (expq[d].size() < len) expq[d].push_back(idle);
        end
        start = 1'b1;
        @(posedge clk); #1;
        if (mode != 3) start = 1'b0;
        for (int k = 0; k < len; k++) begin
            chk(0, expq[0][k], $sformatf("%s c%0d", name, k));
            chk(1, expq[1][k], $sformatf("%s c%0d", name, k));
            host_wr_en = 1'b0;
            if (mode != 3) start = 1'b0;
            if (mode == 1 && k == at) begin
                host_wr_en   = 1'b1;
                host_wr_addr = 3'd3;
                host_wr_data = 16'hFFFF;
            end
            if (mode == 2 && k == at) start = 1'b1;
            if (mode == 3 && k == tlen + 1) start = 1'b0;
            if (mode == 4 && k == at) begin
                reset = 1'b0;
                #2;
                chk(0, mk(16'h0, 1'b0, 1'b0, 3'd0, 1'b0), {name, " async"});
                chk(1, mk(16'h0, 1'b0, 1'b0, 3'd0, 1'b0), {name, " async"});
                #2 reset = 1'b1;
                for (int i = 0; i < 8; i++) mem[i] = 16'h0;
                return;
            end
            @(posedge clk); #1;
        end
        host_wr_en = 1'b0;
        start      = 1'b0;
    endtask

    logic [15:0] std_prog [8];
    logic [15:0] rnd_prog [8];
    logic [2:0]  op;
    int          r;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset        = 1'b0;
        host_wr_en   = 1'b0;
        host_wr_addr = 3'd0;
        host_wr_data = 16'h0;
        start        = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 16'h0;
        std_prog = '{16'h200F, 16'h4000, 16'h201E, 16'h6000,
                     16'h8000, 16'h2007, 16'hA000, 16'h0000};

        repeat (2) @(posedge clk);
        #1;
        chk(0, mk(16'h0, 1'b0, 1'b0, 3'd0, 1'b0), "reset");
        chk(1, mk(16'h0, 1'b0, 1'b0, 3'd0, 1'b0), "reset");
        reset = 1'b1;
        @(posedge clk); #1;

        load(std_prog);
        run(0, 0, "std");

        wr(0, 16'h8000);
        wr(1, 16'h0000);
        run(0, 0, "compute");

        wr(0, 16'h2001);
        wr(1, 16'hC000);
        run(0, 0, "illegal");

        for (int i = 0; i < 8; i++) wr(i, 16'h4000);
        run(0, 0, "noend");

        load(std_prog);
        run(1, 4, "wrbusy");
        run(0, 0, "readback");
        run(2, 6, "midstart");

        wr(0, 16'h2001);
        wr(1, 16'h4002);
        wr(2, 16'h0000);
        run(3, 0, "hold");

        load(std_prog);
        run(4, 10, "rst");
        @(posedge clk); #1;
        run(0, 0, "postrst");

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 8; i++) begin
                r = $urandom_range(0, 15);
                if (r < 11)      op = 3'((r % 5) + 1);
                else if (r < 13) op = 3'd4;
                else             op = 3'($urandom_range(0, 7));
                rnd_prog[i] = {op, 13'($urandom)};
            end
            load(rnd_prog);
            run(0, 0, $sformatf("rand%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
